// File: rtl/regfile_pkg.sv
//------------------------------------------------------------------------------
// Module   : regfile_pkg
// Brief    : Shared constants and types for the register-file write-back slice.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t addr;
        reg_data_t data;
    } wb_req_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_REQ0 = 2'd1,
        GNT_REQ1 = 2'd2
    } grant_t;

endpackage

`default_nettype wire

// File: rtl/regfile_wb_ctrl_rr_arb2.sv
//------------------------------------------------------------------------------
// Module   : rr_arb2
// Brief    : Two-requester round-robin arbiter with hold; ready is combinational.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arb2
    import regfile_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   hold,
    input  logic   req0_valid,
    input  logic   req1_valid,
    output logic   req0_ready,
    output logic   req1_ready,
    output grant_t grant
);

    // 1 means req1 was granted last, so req0 wins the next tie
    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        grant        = GNT_NONE;
        last_grant_d = last_grant_q;
        if (!hold) begin
            if (req0_valid && req1_valid) begin
                grant = last_grant_q ? GNT_REQ0 : GNT_REQ1;
            end else if (req0_valid) begin
                grant = GNT_REQ0;
            end else if (req1_valid) begin
                grant = GNT_REQ1;
            end
        end
        if (grant == GNT_REQ0) begin
            last_grant_d = 1'b0;
        end else if (grant == GNT_REQ1) begin
            last_grant_d = 1'b1;
        end
    end

    assign req0_ready = (grant == GNT_REQ0);
    assign req1_ready = (grant == GNT_REQ1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_ctrl.sv
//------------------------------------------------------------------------------
// Module   : regfile_wb_ctrl
// Brief    : Write-port arbiter and pending-write scoreboard for the register
//            file. Optional forwarding outputs under REGFILE_WB_FWD_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_wb_ctrl
    import regfile_pkg::*;
#(
    parameter int WIDTH_ADDR = REG_ADDR_W,
    parameter int WIDTH_DATA = REG_DATA_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wb_hold,
    input  logic                       req0_valid,
    input  logic [WIDTH_ADDR-1:0]      req0_addr,
    input  logic [WIDTH_DATA-1:0]      req0_data,
    output logic                       req0_ready,
    input  logic                       req1_valid,
    input  logic [WIDTH_ADDR-1:0]      req1_addr,
    input  logic [WIDTH_DATA-1:0]      req1_data,
    output logic                       req1_ready,
    input  logic                       sb_set,
    input  logic [WIDTH_ADDR-1:0]      sb_addr,
    input  logic [WIDTH_ADDR-1:0]      ra1,
    input  logic [WIDTH_ADDR-1:0]      ra2,
    output logic                       hazard1,
    output logic                       hazard2,
    output logic                       we3,
    output logic [WIDTH_ADDR-1:0]      wa3,
    output logic [WIDTH_DATA-1:0]      wd3,
    output logic                       sb_err,
`ifdef REGFILE_WB_FWD_EN
    output logic                       fwd1_valid,
    output logic                       fwd2_valid,
    output logic [WIDTH_DATA-1:0]      fwd1_data,
    output logic [WIDTH_DATA-1:0]      fwd2_data,
`endif
    output logic [(2**WIDTH_ADDR)-1:0] busy_vec
);

    localparam int c_NUM_ENTRIES = 2**WIDTH_ADDR;

    grant_t                   w_grant;
    logic                     we3_q, we3_d;
    logic [WIDTH_ADDR-1:0]    wa3_q, wa3_d;
    logic [WIDTH_DATA-1:0]    wd3_q, wd3_d;
    logic [c_NUM_ENTRIES-1:0] busy_vec_q, busy_vec_d;
    logic                     sb_err_q, sb_err_d;
    logic                     w_wb_hit1, w_wb_hit2;

    rr_arb2 u_arb (
        .clk        (clk),
        .reset      (reset),
        .hold       (wb_hold),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .grant      (w_grant)
    );

    always_comb begin
        we3_d = 1'b0;
        wa3_d = wa3_q;
        wd3_d = wd3_q;
        if (w_grant == GNT_REQ0) begin
            we3_d = (req0_addr != '0);
            wa3_d = req0_addr;
            wd3_d = req0_data;
        end else if (w_grant == GNT_REQ1) begin
            we3_d = (req1_addr != '0);
            wa3_d = req1_addr;
            wd3_d = req1_data;
        end
    end

    // Clear is applied before set so a same-cycle set on that address wins.
    // Address 0 is never tracked, so it can neither set, clear nor raise an error.
    always_comb begin
        busy_vec_d = busy_vec_q;
        sb_err_d   = sb_err_q;
        if ((w_grant == GNT_REQ1) && (req1_addr != '0)) begin
            if (!busy_vec_q[req1_addr]) begin
                sb_err_d = 1'b1;
            end
            busy_vec_d[req1_addr] = 1'b0;
        end
        if (sb_set && (sb_addr != '0)) begin
            if (busy_vec_q[sb_addr]) begin
                sb_err_d = 1'b1;
            end
            busy_vec_d[sb_addr] = 1'b1;
        end
        busy_vec_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we3_q      <= 1'b0;
            wa3_q      <= '0;
            wd3_q      <= '0;
            busy_vec_q <= '0;
            sb_err_q   <= 1'b0;
        end else begin
            we3_q      <= we3_d;
            wa3_q      <= wa3_d;
            wd3_q      <= wd3_d;
            busy_vec_q <= busy_vec_d;
            sb_err_q   <= sb_err_d;
        end
    end

    assign we3      = we3_q;
    assign wa3      = wa3_q;
    assign wd3      = wd3_q;
    assign busy_vec = busy_vec_q;
    assign sb_err   = sb_err_q;

    // A write sitting on the port this cycle is not yet visible in the file
    assign w_wb_hit1 = we3_q && (wa3_q == ra1);
    assign w_wb_hit2 = we3_q && (wa3_q == ra2);

`ifdef REGFILE_WB_FWD_EN
    assign hazard1    = (ra1 != '0) && busy_vec_q[ra1];
    assign hazard2    = (ra2 != '0) && busy_vec_q[ra2];
    assign fwd1_valid = w_wb_hit1 && (ra1 != '0);
    assign fwd2_valid = w_wb_hit2 && (ra2 != '0);
    assign fwd1_data  = wd3_q;
    assign fwd2_data  = wd3_q;
`else
    assign hazard1 = (ra1 != '0) && (busy_vec_q[ra1] || w_wb_hit1);
    assign hazard2 = (ra2 != '0) && (busy_vec_q[ra2] || w_wb_hit2);
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_regfile_wb_ctrl
// Brief    : Directed self-checking bench for regfile_wb_ctrl.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_regfile_wb_ctrl;

`ifdef REGFILE_WB_FWD_EN
    localparam bit c_FWD = 1'b1;
`else
    localparam bit c_FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_hold;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        sb_set;
    logic [4:0]  sb_addr, ra1, ra2;
    logic        hazard1, hazard2;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic        sb_err;
    logic [31:0] busy_vec;
`ifdef REGFILE_WB_FWD_EN
    logic        fwd1_valid, fwd2_valid;
    logic [31:0] fwd1_data, fwd2_data;
`endif

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 clk = ~clk;

    regfile_wb_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .wb_hold    (wb_hold),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .sb_set     (sb_set),
        .sb_addr    (sb_addr),
        .ra1        (ra1),
        .ra2        (ra2),
        .hazard1    (hazard1),
        .hazard2    (hazard2),
        .we3        (we3),
        .wa3        (wa3),
        .wd3        (wd3),
        .sb_err     (sb_err),
`ifdef REGFILE_WB_FWD_EN
        .fwd1_valid (fwd1_valid),
        .fwd2_valid (fwd2_valid),
        .fwd1_data  (fwd1_data),
        .fwd2_data  (fwd2_data),
`endif
        .busy_vec   (busy_vec)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are then driven 2ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        wb_hold    = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        sb_set     = 1'b0; sb_addr   = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k0, k1;
        logic [4:0] exp_wa;
        logic       exp_g0;

        reset = 1'b1;
        ra1 = '0; ra2 = '0;
        idle_inputs();
        tick(); tick();
        #1;
        check("rst_we3", we3, 0);
        check("rst_wa3", wa3, 0);
        check("rst_wd3", wd3, 0);
        check("rst_busy", busy_vec, 0);
        check("rst_err", sb_err, 0);
        reset = 1'b0;

        // Stream a req0 write plus a scoreboard set, then reset mid-stream
        tick();
        req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h11;
        sb_set = 1'b1; sb_addr = 5'd2;
        #1;
        check("pre_r0_ready", req0_ready, 1);
        tick();
        sb_set = 1'b0;
        #1;
        check("pre_we3", we3, 1);
        check("pre_wa3", wa3, 4);
        check("pre_busy", busy_vec, 32'h4);
        reset = 1'b1;
        #1;
        check("mid_rst_we3", we3, 0);
        check("mid_rst_busy", busy_vec, 0);
        check("mid_rst_err", sb_err, 0);
        check("mid_rst_wa3", wa3, 0);
        tick();
        req0_valid = 1'b0;
        reset = 1'b0;

        // Pre-mark the req1 destinations so its clears are legal
        for (int i = 0; i < 3; i++) begin
            sb_set = 1'b1; sb_addr = 5'(20 + i);
            tick();
        end
        sb_set = 1'b0;
        #1;
        check("sb_pre_busy", busy_vec, 32'h0070_0000);

        // Contention: both valid for six cycles, grants alternate starting with req0
        k0 = 0; k1 = 0; exp_wa = '0;
        for (int i = 0; i < 6; i++) begin
            req0_valid = 1'b1; req0_addr = 5'(10 + k0); req0_data = 32'hA000_0000 + 32'(10 + k0);
            req1_valid = 1'b1; req1_addr = 5'(20 + k1); req1_data = 32'hB000_0000 + 32'(20 + k1);
            #1;
            exp_g0 = (i % 2 == 0);
            check($sformatf("ct_r0_ready%0d", i), req0_ready, 32'(exp_g0));
            check($sformatf("ct_r1_ready%0d", i), req1_ready, 32'(!exp_g0));
            if (i > 0) begin
                check($sformatf("ct_wa3_%0d", i), wa3, 32'(exp_wa));
                check($sformatf("ct_we3_%0d", i), we3, 1);
            end
            if (exp_g0) begin
                exp_wa = 5'(10 + k0); k0++;
            end else begin
                exp_wa = 5'(20 + k1); k1++;
            end
            tick();
        end
        idle_inputs();
        #1;
        check("ct_wa3_last", wa3, 22);
        check("ct_wd3_last", wd3, 32'hB000_0016);
        check("ct_busy", busy_vec, 0);
        check("ct_err", sb_err, 0);

        // Scoreboard: mark r7 busy, retire it via req1
        sb_set = 1'b1; sb_addr = 5'd7;
        tick();
        sb_set = 1'b0;
        ra1 = 5'd7; ra2 = 5'd7;
        #1;
        check("sb_busy7", busy_vec[7], 1);
        check("sb_haz1_busy", hazard1, 1);
        check("sb_haz2_busy", hazard2, 1);
        req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'hDEAD_BEEF;
        #1;
        check("sb_r1_ready", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        #1;
        check("sb_busy7_clr", busy_vec[7], 0);
        check("sb_we3", we3, 1);
        check("sb_wa3", wa3, 7);
        check("sb_wd3", wd3, 32'hDEAD_BEEF);
        check("sb_haz1_wb", hazard1, 32'(!c_FWD));
        check("sb_haz2_wb", hazard2, 32'(!c_FWD));
`ifdef REGFILE_WB_FWD_EN
        check("fwd1_valid", fwd1_valid, 1);
        check("fwd1_data", fwd1_data, 32'hDEAD_BEEF);
        check("fwd2_valid", fwd2_valid, 1);
`endif
        tick();
        #1;
        check("sb_haz1_done", hazard1, 0);
        check("sb_we3_done", we3, 0);
        check("sb_err_clean", sb_err, 0);

        // Zero register
        req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'h55;
        sb_set = 1'b1; sb_addr = 5'd0;
        ra1 = 5'd0;
        #1;
        check("z_r0_ready", req0_ready, 1);
        check("z_haz1", hazard1, 0);
        tick();
        idle_inputs();
        #1;
        check("z_we3", we3, 0);
        check("z_busy", busy_vec, 0);
        check("z_haz1_after", hazard1, 0);
        check("z_err", sb_err, 0);

        // Protocol error: double set
        sb_set = 1'b1; sb_addr = 5'd3;
        tick();
        #1;
        check("pe_err_first", sb_err, 0);
        tick();
        sb_set = 1'b0;
        #1;
        check("pe_err_double", sb_err, 1);
        tick();
        #1;
        check("pe_err_sticky", sb_err, 1);
        check("pe_busy3", busy_vec, 32'h8);

        // Protocol error: clear of a non-busy register
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("pe_err_rst", sb_err, 0);
        req1_valid = 1'b1; req1_addr = 5'd5; req1_data = 32'h5;
        tick();
        req1_valid = 1'b0;
        #1;
        check("pe_err_clr", sb_err, 1);
        check("pe_busy_clr", busy_vec, 0);

        // Hold blocks all grants
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wb_hold = 1'b1;
        req0_valid = 1'b1; req0_addr = 5'd8; req0_data = 32'h8;
        req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h9;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("h_r0_ready%0d", i), req0_ready, 0);
            check($sformatf("h_r1_ready%0d", i), req1_ready, 0);
            tick();
            #1;
            check($sformatf("h_we3_%0d", i), we3, 0);
        end

        // Set and clear of r9 in the same cycle: set wins
        wb_hold = 1'b0;
        req0_valid = 1'b0;
        sb_set = 1'b1; sb_addr = 5'd9;
        #1;
        check("sim_r1_ready", req1_ready, 1);
        tick();
        idle_inputs();
        #1;
        check("sim_busy9", busy_vec[9], 1);
        check("sim_we3", we3, 1);
        check("sim_wa3", wa3, 9);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
- Write-back controller and scoreboard for the 32-entry register file.
- Shares the file's single write port (we3/wa3/wd3) between two requesters:
  - req0: single-cycle ALU/load path.
  - req1: long-latency unit, e.g. mult/div.
- Uses round-robin arbitration with valid/ready handshakes.
- Tracks registers with pending long-latency writes and flags read hazards on both read addresses so the pipeline can stall.

Parameters:
- WIDTH_ADDR, 5, register address width; the file has 2**WIDTH_ADDR entries.
- WIDTH_DATA, 32, register data width.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- wb_hold  input  1  pipeline hold; no grants are issued while high.
- req0_valid  input  1  requester 0 has a write.
- req0_addr  input  WIDTH_ADDR  requester 0 destination register.
- req0_data  input  WIDTH_DATA  requester 0 write data.
- req0_ready  output  1  requester 0 granted this cycle.
- req1_valid / req1_addr / req1_data / req1_ready  same as req0, for requester 1.
- sb_set  input  1  long-latency op issued; mark sb_addr busy.
- sb_addr  input  WIDTH_ADDR  destination register of the issued op.
- ra1, ra2  input  WIDTH_ADDR  read addresses being decoded.
- hazard1, hazard2  output  1  the matching read must stall.
- we3  output  1  register file write enable (registered).
- wa3  output  WIDTH_ADDR  register file write address (registered).
- wd3  output  WIDTH_DATA  register file write data (registered).
- sb_err  output  1  sticky scoreboard protocol error.
- busy_vec  output  2**WIDTH_ADDR  scoreboard state, for debug.

Behaviour:
- Reset (asynchronous, active-high): we3=0, wa3=0, wd3=0, busy_vec=0, sb_err=0, last_grant=1 (req0 wins the first tie). Reset mid-operation discards any in-flight write; nothing is written to the file.
- Transfer rule: a transfer occurs when reqN_valid and reqN_ready are both high at a posedge.
- reqN_ready is combinational from the valid inputs, last_grant and wb_hold:
  - At most one ready is high per cycle.
  - ready is never high while the matching valid is low, or while wb_hold=1.
- Arbitration:
  - Only one valid: grant it.
  - Both valid: grant the requester that is not last_grant.
  - last_grant updates only on a transfer.
  - Requesters must hold valid/addr/data stable until ready.
- Write port:
  - On a transfer at edge N, we3/wa3/wd3 carry that write during cycle N+1; the file captures it at edge N+1.
  - With no transfer, we3=0 and wa3/wd3 hold their previous values.
  - addr=0 transfers are accepted but produce we3=0.
- Scoreboard (busy_vec):
  - Bit 0 is hardwired to 0.
  - sb_set with sb_addr!=0 sets the bit at the next edge.
  - A req1 transfer clears bit req1_addr at the same edge.
  - Set and clear of the same address in the same cycle: set wins.
  - sb_set on a bit that is already set, or a req1 clear of a bit that is not set: sb_err=1, sticky until reset. The bit update still applies.
  - req0 transfers never touch busy_vec.
- Hazards, combinational:
  - hazardK = (raK!=0) and (busy_vec[raK] or (we3 and wa3==raK)).
  - The second term covers the one-cycle write-port latency.
- Throughput: one write per cycle sustained. The starvation bound under continuous dual requests is 1 cycle.

Optional Feature:
- Macro: REGFILE_WB_FWD_EN.
- Defined:
  - Adds outputs fwd1_valid/fwd2_valid (1 bit) and fwd1_data/fwd2_data (WIDTH_DATA).
  - fwdK_valid = we3 and wa3==raK and raK!=0; fwdK_data = wd3.
  - The we3 term is removed from hazardK, so only busy_vec stalls.
- Undefined: no forwarding ports; hazards are as above.

Decomposition:
- Package regfile_pkg:
  - Constants REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS.
  - Typedefs reg_addr_t, reg_data_t, wb_req_t (valid/addr/data struct).
  - Enum grant_t {GNT_NONE, GNT_REQ0, GNT_REQ1}.
- Sub-module rr_arb2: two-requester round-robin arbiter with hold input and last_grant state. The scoreboard stays inline.

Test Plan:
- Reset check: assert reset mid-stream with req0_valid=1 -> we3=0, busy_vec=0, sb_err=0 immediately; after release, req0 and req1 both valid -> req0 granted first.
- Contention: req0 and req1 both valid every cycle for 6 cycles -> grants alternate 0,1,0,1,0,1; wa3 sequence matches one cycle later.
- Scoreboard: sb_set addr 7; ra1=7 -> hazard1=1; req1 writes addr 7 data 0xDEADBEEF -> busy_vec[7]=0 after the edge, we3=1/wa3=7 the next cycle, hazard1=1 that cycle only (0 with REGFILE_WB_FWD_EN, fwd1_data=0xDEADBEEF), then 0.
- Zero register: req0 writes addr 0 and sb_set addr 0 -> req0_ready=1, we3 stays 0, busy_vec[0]=0, hazard1=0 for ra1=0.
- Protocol error: sb_set addr 3 twice -> sb_err=1 and stays set; separately, a req1 write to non-busy addr 5 -> sb_err=1.
- Hold and simultaneity: wb_hold=1 for 3 cycles with both valid -> both readies 0, no we3; sb_set addr 9 in the same cycle as a req1 commit to addr 9 -> busy_vec[9]=1.
